// File: rtl/obst_scan_multi.sv
// Multi-player obstacle scanner: shares one tile-map read port across NUM_PLAYERS sprites.
// Optional free-running mode via OBST_SCAN_FREE_RUN_EN (default: start-triggered passes).
module obst_scan_multi #(
   parameter int NUM_PLAYERS   = 2,
   parameter int NUM_ROW       = 11,
   parameter int NUM_COL       = 19,
   parameter int TILE_PX       = 64,
   parameter int SPRITE_W      = 32,
   parameter int SPRITE_H      = 64,
   parameter int MAP_MEM_WIDTH = 2,
   parameter int RD_LAT        = 1
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            start,
   input  logic [NUM_PLAYERS*11-1:0]                       player_x,
   input  logic [NUM_PLAYERS*10-1:0]                       player_y,
   output logic [$clog2(NUM_ROW*NUM_COL)-1:0]              map_addr,
   output logic                                            map_rd_en,
   input  logic [MAP_MEM_WIDTH:0]                          map_mem_in,
   output logic [NUM_PLAYERS*4-1:0]                        obstacles,
   output logic [NUM_PLAYERS*4*($clog2(TILE_PX)+1)-1:0]    obstacle_dist,
   output logic [NUM_PLAYERS-1:0]                          obstacles_valid,
   output logic                                            busy
);
   localparam int TS     = $clog2(TILE_PX);
   localparam int DW     = TS + 1;
   localparam int AW     = $clog2(NUM_ROW*NUM_COL);
   localparam int NPROBE = 8 * NUM_PLAYERS;
   localparam int KW     = $clog2(NPROBE);
   localparam int CW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t state, state_nx;

   logic                      go, accept, load_probe, last_probe;
   logic [KW-1:0]             k_q, pk;
   logic [CW-1:0]             drain_q;
   logic                      iss_v, iss_e;
   logic [NUM_PLAYERS*11-1:0] snap_x, src_x;
   logic [NUM_PLAYERS*10-1:0] snap_y, src_y;
   logic                      pipe_v [RD_LAT];
   logic                      pipe_e [RD_LAT];
   logic [KW-1:0]             pipe_k [RD_LAT];
   logic [6:0]                hits_q;
   int                        pp, prow, pcol, trow, tcol;
   logic                      tedge;
   logic [AW-1:0]             taddr;

`ifdef OBST_SCAN_FREE_RUN_EN
   logic started_q;
   assign go   = 1'b1;
   assign busy = started_q;
   always_ff @(posedge clk) begin
      if (rst)         started_q <= 1'b0;
      else if (accept) started_q <= 1'b1;
   end
`else
   assign go   = start;
   assign busy = (state != IDLE);
`endif

   assign last_probe = (k_q == KW'(NPROBE-1));
   assign accept     = (state == IDLE) && go;
   assign load_probe = accept || ((state == ISSUE) && !last_probe);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (go) state_nx = ISSUE;
         ISSUE:   if (last_probe) state_nx = DRAIN;
         DRAIN:   if (drain_q == CW'(RD_LAT-1)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Probe 0 is registered on the accept edge, so it is built from the live inputs.
   always_comb begin
      pk    = accept ? '0 : k_q + KW'(1);
      src_x = accept ? player_x : snap_x;
      src_y = accept ? player_y : snap_y;
      pp    = int'(pk >> 3);
      prow  = int'(src_y[10*pp +: 10] >> TS);
      pcol  = int'(src_x[11*pp +: 11] >> TS);
      trow  = prow;
      tcol  = pcol;
      case (pk[2:0])
         3'd0: begin trow = prow - 1; tcol = pcol;     end
         3'd1: begin trow = prow - 1; tcol = pcol + 1; end
         3'd2: begin trow = prow + 1; tcol = pcol;     end
         3'd3: begin trow = prow + 1; tcol = pcol + 1; end
         3'd4: begin trow = prow;     tcol = pcol - 1; end
         3'd5: begin trow = prow + 1; tcol = pcol - 1; end
         3'd6: begin trow = prow;     tcol = pcol + 1; end
         default: begin trow = prow + 1; tcol = pcol + 1; end
      endcase
      tedge = (trow <= 0) || (trow >= NUM_ROW-1) || (tcol <= 0) || (tcol >= NUM_COL-1);
      taddr = tedge ? '0 : AW'(trow*NUM_COL + tcol);
   end

   logic                samp_v, samp_hit, commit, sh, sv;
   logic [KW-1:0]       samp_k;
   logic [7:0]          h;
   logic [3:0]          hit, eob, new_obs;
   logic [4*DW-1:0]     new_dist;
   int                  cp, ox, oy, dn, rt;

   always_comb begin
      samp_v   = pipe_v[RD_LAT-1];
      samp_k   = pipe_k[RD_LAT-1];
      samp_hit = pipe_e[RD_LAT-1] | (map_mem_in != '0);
      commit   = samp_v && (samp_k[2:0] == 3'd7);
      cp       = int'(samp_k >> 3);
      ox       = int'(snap_x[11*cp +: TS]);
      oy       = int'(snap_y[10*cp +: TS]);
      h        = {samp_hit, hits_q};
      sh       = (ox + SPRITE_W) > TILE_PX;
      sv       = (oy + SPRITE_H) > TILE_PX;
      hit[0]   = h[0] | (sh & h[1]);
      hit[1]   = h[2] | (sh & h[3]);
      hit[2]   = h[4] | (sv & h[5]);
      hit[3]   = h[6] | (sv & h[7]);
      eob[0]   = (oy == 0);
      eob[1]   = (oy + SPRITE_H) >= TILE_PX;
      eob[2]   = (ox == 0);
      eob[3]   = (ox + SPRITE_W) >= TILE_PX;
      dn       = eob[1] ? 0 : TILE_PX - (oy + SPRITE_H);
      rt       = eob[3] ? 0 : TILE_PX - (ox + SPRITE_W);
      new_obs  = eob & hit;
      new_dist = '1;
      if (hit[0]) new_dist[0*DW +: DW] = DW'(oy);
      if (hit[1]) new_dist[1*DW +: DW] = DW'(dn);
      if (hit[2]) new_dist[2*DW +: DW] = DW'(ox);
      if (hit[3]) new_dist[3*DW +: DW] = DW'(rt);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         map_addr        <= '0;
         map_rd_en       <= 1'b0;
         k_q             <= '0;
         iss_v           <= 1'b0;
         iss_e           <= 1'b0;
         drain_q         <= '0;
         snap_x          <= '0;
         snap_y          <= '0;
         hits_q          <= '0;
         obstacles       <= '0;
         obstacle_dist   <= '1;
         obstacles_valid <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_e[i] <= 1'b0;
            pipe_k[i] <= '0;
         end
      end else begin
         map_rd_en       <= 1'b0;
         iss_v           <= load_probe;
         obstacles_valid <= '0;
         drain_q         <= (state == DRAIN) ? drain_q + CW'(1) : '0;
         if (load_probe) begin
            map_addr  <= taddr;
            map_rd_en <= ~tedge;
            k_q       <= pk;
            iss_e     <= tedge;
         end
         if (accept) begin
            snap_x <= player_x;
            snap_y <= player_y;
         end
         pipe_v[0] <= iss_v;
         pipe_e[0] <= iss_e;
         pipe_k[0] <= k_q;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_e[i] <= pipe_e[i-1];
            pipe_k[i] <= pipe_k[i-1];
         end
         if (samp_v && !commit) hits_q[samp_k[2:0]] <= samp_hit;
         if (commit) begin
            obstacles[4*cp +: 4]             <= new_obs;
            obstacle_dist[4*DW*cp +: 4*DW]   <= new_dist;
            obstacles_valid[cp]              <= 1'b1;
         end
      end
   end
endmodule
